// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter. It takes whole words over a valid/ready handshake and drives a framed serial line.
// Frame format, baud period and line-break generation are all selected at run time.
module uart_tx_core #(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MAX_DATA_BITS-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [3:0]               cfg_data_bits,
   input  logic [2:0]               cfg_parity,
   input  logic [1:0]               cfg_stop,
   input  logic                     cfg_msb_first,
   input  logic [DIV_WIDTH-1:0]     baud_div,
   input  logic                     break_req,
   output logic                     tx_data,
   output logic                     tx_busy,
   output logic                     frame_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
   typedef enum logic [2:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE} par_e;

   // STOP can last up to 2P cycles, so the bit timer is one bit wider than baud_div.
   localparam int CW = DIV_WIDTH + 1;

   state_e                   state_q, state_d;
   par_e                     par_q, par_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]     per_q, per_d;
   logic [MAX_DATA_BITS-1:0] data_q, data_d;
   logic [3:0]               nbits_q, nbits_d, idx_q, idx_d;
   logic [1:0]               stop_q, stop_d;
   logic                     msb_q, msb_d, mab_q, mab_d;
   logic                     tx_q, tx_d, busy_q, busy_d, done_q, done_d;

   logic                     accept, cnt_zero, data_bit, parity_bit;
   logic [3:0]               n_in, nxt_idx, sel;
   logic [DIV_WIDTH-1:0]     p_in;
   par_e                     par_in;
   logic [MAX_DATA_BITS-1:0] mask_in, shifted;
   logic [CW-1:0]            p_in_m1, per_m1, stop_m1;

   assign cnt_zero = (cnt_q == '0);
   assign s_ready  = ~reset & ~break_req & ((state_q == IDLE) | ((state_q == STOP) & cnt_zero));
   assign accept   = s_valid & s_ready;

   // Clamped view of the live configuration; only sampled when a word is accepted.
   always_comb begin
      if (cfg_data_bits < 4'd5)                       n_in = 4'd5;
      else if (cfg_data_bits > 4'(MAX_DATA_BITS))     n_in = 4'(MAX_DATA_BITS);
      else                                            n_in = cfg_data_bits;
      p_in    = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
      p_in_m1 = CW'(p_in) - CW'(1);
      mask_in = ~({MAX_DATA_BITS{1'b1}} << n_in);
      case (cfg_parity)
         3'd1:    par_in = PAR_EVEN;
         3'd2:    par_in = PAR_ODD;
         3'd3:    par_in = PAR_MARK;
         3'd4:    par_in = PAR_SPACE;
         default: par_in = PAR_NONE;
      endcase
   end

   always_comb begin
      per_m1 = CW'(per_q) - CW'(1);
      case (stop_q)
         2'd0:    stop_m1 = per_m1;
         2'd1:    stop_m1 = per_m1 + CW'(per_q >> 1);
         default: stop_m1 = per_m1 + CW'(per_q);
      endcase
      // Selects the data bit for the slot about to be entered.
      nxt_idx  = (state_q == DATA) ? idx_q + 4'd1 : 4'd0;
      sel      = msb_q ? nbits_q - 4'd1 - nxt_idx : nxt_idx;
      shifted  = data_q >> sel;
      data_bit = shifted[0];
      case (par_q)
         PAR_EVEN: parity_bit = ^data_q;
         PAR_ODD:  parity_bit = ~^data_q;
         PAR_MARK: parity_bit = 1'b1;
         default:  parity_bit = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every *_d gets a default first so no path through the case can infer a latch.
      state_d = state_q;
      par_d   = par_q;
      cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
      per_d   = per_q;
      data_d  = data_q;
      nbits_d = nbits_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      msb_d   = msb_q;
      mab_d   = mab_q;
      tx_d    = tx_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (break_req) begin
               state_d = BREAK;
               per_d   = p_in;
               cnt_d   = p_in_m1;
               mab_d   = 1'b0;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (cnt_zero) begin
               state_d = DATA;
               idx_d   = nxt_idx;
               cnt_d   = per_m1;
               tx_d    = data_bit;
            end
         end
         DATA: begin
            if (cnt_zero) begin
               if (idx_q == nbits_q - 4'd1) begin
                  if (par_q != PAR_NONE) begin
                     state_d = PARITY;
                     cnt_d   = per_m1;
                     tx_d    = parity_bit;
                  end else begin
                     state_d = STOP;
                     cnt_d   = stop_m1;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = nxt_idx;
                  cnt_d = per_m1;
                  tx_d  = data_bit;
               end
            end
         end
         PARITY: begin
            if (cnt_zero) begin
               state_d = STOP;
               cnt_d   = stop_m1;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            done_d = (cnt_q == CW'(1));
            if (cnt_zero) state_d = IDLE;
         end
         BREAK: begin
            // Low phase holds while break_req is high and at least P cycles, then P cycles of mark.
            if (!mab_q) begin
               if (cnt_zero && !break_req) begin
                  mab_d = 1'b1;
                  cnt_d = per_m1;
                  tx_d  = 1'b1;
               end
            end else if (cnt_zero) begin
               state_d = IDLE;
               mab_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = START;
         per_d   = p_in;
         cnt_d   = p_in_m1;
         data_d  = s_data & mask_in;
         nbits_d = n_in;
         par_d   = par_in;
         stop_d  = cfg_stop;
         msb_d   = cfg_msb_first;
         idx_d   = 4'd0;
         mab_d   = 1'b0;
         tx_d    = 1'b0;
      end
   end

   assign busy_d = (state_d != IDLE);

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         par_q   <= PAR_NONE;
         cnt_q   <= '0;
         per_q   <= '0;
         data_q  <= '0;
         nbits_q <= '0;
         idx_q   <= '0;
         stop_q  <= '0;
         msb_q   <= 1'b0;
         mab_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         data_q  <= data_d;
         nbits_q <= nbits_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         msb_q   <= msb_d;
         mab_q   <= mab_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_data    = tx_q;
   assign tx_busy    = busy_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core. Each frame is expanded by a reference model into a per-cycle line waveform,
// and the DUT is compared against it on every cycle, together with busy, done and ready.
module tb_uart_tx_core;
   localparam int MDB = 9;
   localparam int DW  = 16;

   typedef struct {
      logic [8:0]  word;
      logic [3:0]  nb;
      logic [2:0]  par;
      logic [1:0]  stp;
      logic        msb;
      logic [15:0] div;
      int          brk_at;
   } frame_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [MDB-1:0] s_data;
   logic           s_valid;
   logic           s_ready;
   logic [3:0]     cfg_data_bits;
   logic [2:0]     cfg_parity;
   logic [1:0]     cfg_stop;
   logic           cfg_msb_first;
   logic [DW-1:0]  baud_div;
   logic           break_req;
   logic           tx_data;
   logic           tx_busy;
   logic           frame_done;

   int     n_cmp = 0;
   int     n_err = 0;
   bit     exp_q[$];
   frame_t plan[$];

   always #5 clk = ~clk;

   uart_tx_core #(.MAX_DATA_BITS(MDB), .DIV_WIDTH(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop      (cfg_stop),
      .cfg_msb_first (cfg_msb_first),
      .baud_div      (baud_div),
      .break_req     (break_req),
      .tx_data       (tx_data),
      .tx_busy       (tx_busy),
      .frame_done    (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic frame_t mk(input logic [8:0] w, input int nb, input int par, input int stp,
                                 input int msb, input int div, input int brk_at);
      frame_t f;
      f.word   = w;
      f.nb     = 4'(nb);
      f.par    = 3'(par);
      f.stp    = 2'(stp);
      f.msb    = 1'(msb);
      f.div    = 16'(div);
      f.brk_at = brk_at;
      return f;
   endfunction

   function automatic frame_t rand_frame();
      return mk(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 6), 0);
   endfunction

   function automatic int clamp_p(input logic [15:0] div);
      return (div < 16'd2) ? 2 : int'(div);
   endfunction

   // Reference model: expected line level for each cycle after the accept edge.
   task automatic build(input frame_t f);
      int n, p, ones, slen;
      bit b;
      exp_q.delete();
      n = (f.nb < 4'd5) ? 5 : (f.nb > 4'd9) ? 9 : int'(f.nb);
      p = clamp_p(f.div);
      ones = 0;
      repeat (p) exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         b = f.msb ? f.word[n-1-i] : f.word[i];
         ones += int'(f.word[i]);
         repeat (p) exp_q.push_back(b);
      end
      case (f.par)
         3'd1: repeat (p) exp_q.push_back(ones % 2 == 1);
         3'd2: repeat (p) exp_q.push_back(ones % 2 == 0);
         3'd3: repeat (p) exp_q.push_back(1'b1);
         3'd4: repeat (p) exp_q.push_back(1'b0);
         default: ;
      endcase
      case (f.stp)
         2'd0:    slen = p;
         2'd1:    slen = p + p / 2;
         default: slen = 2 * p;
      endcase
      repeat (slen) exp_q.push_back(1'b1);
   endtask

   task automatic apply(input frame_t f);
      s_data        = f.word;
      cfg_data_bits = f.nb;
      cfg_parity    = f.par;
      cfg_stop      = f.stp;
      cfg_msb_first = f.msb;
      baud_div      = f.div;
   endtask

   // Runs the frames in plan back to back; called at a negedge with the DUT idle.
   task automatic run_plan();
      int len;
      bit brk;
      apply(plan[0]);
      s_valid = 1'b1;
      #1;
      check("rdy_idle", s_ready, 1);
      check("busy_idle", tx_busy, 0);
      for (int f = 0; f < plan.size(); f++) begin
         build(plan[f]);
         len = exp_q.size();
         brk = (plan[f].brk_at != 0);
         @(posedge clk);
         #1;
         if (f + 1 < plan.size()) begin
            apply(plan[f+1]);
            s_valid = 1'b1;
         end else begin
            apply(rand_frame());
            s_valid = 1'b0;
         end
         for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check($sformatf("tx f%0d c%0d", f, k), tx_data, exp_q[k-1]);
            check($sformatf("busy f%0d c%0d", f, k), tx_busy, 1);
            check($sformatf("done f%0d c%0d", f, k), frame_done, k == len);
            check($sformatf("rdy f%0d c%0d", f, k), s_ready, (k == len) && !brk);
            if (k == plan[f].brk_at) break_req = 1'b1;
         end
         if (brk) return;
      end
      @(negedge clk);
      check("tx_after", tx_data, 1);
      check("busy_after", tx_busy, 0);
      check("done_after", frame_done, 0);
   endtask

   // Break with break_req sampled high for h edges starting at the next edge; DUT idle now.
   task automatic break_phase(input int h, input logic [15:0] div);
      int p, lowlen;
      p = clamp_p(div);
      lowlen = (h > p) ? h : p;
      break_req = 1'b1;
      #1;
      check("brk_rdy0", s_ready, 0);
      check("brk_busy0", tx_busy, 0);
      check("brk_tx0", tx_data, 1);
      for (int c = 1; c <= lowlen + p + 1; c++) begin
         @(negedge clk);
         check($sformatf("brk_tx c%0d", c), tx_data, c > lowlen);
         check($sformatf("brk_busy c%0d", c), tx_busy, c <= lowlen + p);
         check($sformatf("brk_rdy c%0d", c), s_ready, c == lowlen + p + 1);
         check($sformatf("brk_done c%0d", c), frame_done, 0);
         if (c == h) break_req = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f;
      reset     = 1'b1;
      s_valid   = 1'b1;
      break_req = 1'b0;
      apply(mk(9'h0A5, 8, 0, 0, 0, 4, 0));
      repeat (2) @(negedge clk);
      check("rst_tx", tx_data, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_rdy", s_ready, 0);
      reset   = 1'b0;
      s_valid = 1'b0;

      plan = '{mk(9'h0A5, 8, 0, 0, 0, 4, 0)};
      run_plan();
      plan = '{mk(9'h041, 7, 1, 0, 0, 3, 0), mk(9'h041, 7, 2, 0, 0, 3, 0)};
      run_plan();
      plan = '{mk(9'h013, 5, 3, 1, 1, 5, 0)};
      run_plan();
      plan = '{mk(9'h055, 8, 0, 2, 0, 2, 0), mk(9'h0AA, 8, 0, 2, 0, 2, 0),
               mk(9'h13C, 6, 2, 1, 1, 3, 0)};
      run_plan();

      // Break from idle with a word waiting, then the queued word goes out.
      f = mk(9'h0C3, 8, 1, 0, 0, 4, 0);
      apply(f);
      s_valid = 1'b1;
      break_phase(10, f.div);
      plan = '{f};
      run_plan();

      // Break raised mid-frame: the frame completes, then break, then the queued word.
      plan = '{mk(9'h05A, 8, 0, 0, 0, 3, 7), mk(9'h1F0, 9, 2, 2, 1, 4, 0)};
      run_plan();
      @(negedge clk);
      check("brk_mid_idle_busy", tx_busy, 0);
      check("brk_mid_idle_rdy", s_ready, 0);
      break_phase(3, plan[1].div);
      void'(plan.pop_front());
      run_plan();

      // Reset during data bit 3, then a clean frame with baud_div=0.
      f = mk(9'h0A5, 8, 0, 0, 0, 4, 0);
      build(f);
      apply(f);
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         check($sformatf("pre_rst_tx c%0d", k), tx_data, exp_q[k-1]);
      end
      check("pre_rst_busy", tx_busy, 1);
      reset   = 1'b1;
      s_valid = 1'b1;
      #1;
      check("mid_rst_tx", tx_data, 1);
      check("mid_rst_busy", tx_busy, 0);
      check("mid_rst_done", frame_done, 0);
      check("mid_rst_rdy", s_ready, 0);
      @(negedge clk);
      reset   = 1'b0;
      s_valid = 1'b0;
      plan = '{mk(9'h1B6, 9, 1, 0, 0, 0, 0)};
      run_plan();

      // Randomized bursts and a randomized break.
      for (int b = 0; b < 6; b++) begin
         int nf;
         nf = $urandom_range(1, 5);
         plan.delete();
         for (int i = 0; i < nf; i++) plan.push_back(rand_frame());
         run_plan();
      end
      f = rand_frame();
      apply(f);
      s_valid = 1'b1;
      break_phase($urandom_range(1, 12), f.div);
      plan = '{f};
      run_plan();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Parametrised UART transmit engine. It is the successor to the fixed-configuration tx FSM.
- Takes whole words over a valid/ready handshake. No bit-serial buffer read.
- Has its own bit-period timer, so no external sampling ticks are needed.
- Data width, parity mode, stop length and bit order are selected at run time.
- Adds line-break generation and back-to-back frames with no idle gap.
- Sits between the tx FIFO and the pad. Used by the UART top and the DFT bring-up loopback.

Parameters:
MAX_DATA_BITS, 9, width of s_data; legal 5..9
DIV_WIDTH, 16, width of baud_div

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  asynchronous, active-high reset
s_data  input  MAX_DATA_BITS  word to send; bits above cfg_data_bits ignored
s_valid  input  1  s_data valid
s_ready  output  1  core accepts word this cycle
cfg_data_bits  input  4  data bits per frame; <5 clamps to 5, >MAX_DATA_BITS clamps to MAX_DATA_BITS
cfg_parity  input  3  0 none, 1 even, 2 odd, 3 mark(1), 4 space(0); 5..7 = none
cfg_stop  input  2  0 one, 1 one-and-half, 2 or 3 two stop bits
cfg_msb_first  input  1  1 = MSB of the cfg_data_bits field first; 0 = LSB first
baud_div  input  DIV_WIDTH  clk cycles per bit (P); values <2 treated as 2
break_req  input  1  hold line low (break) while high
tx_data  output  1  serial line, idle high
tx_busy  output  1  frame or break in progress
frame_done  output  1  one-cycle pulse on final cycle of a frame's stop period

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, including mid-frame; the frame is aborted with no completion.
  - tx_data=1, tx_busy=0, frame_done=0, state IDLE, all counters 0.
  - s_ready is forced 0 while reset is high.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Handshake:
  - Accept when s_valid & s_ready at a clk edge.
  - s_ready is combinational: (IDLE & ~break_req) | (STOP & last stop cycle & ~break_req).
  - s_data and all cfg_* and baud_div are latched at accept. Later changes do not affect the frame in flight.
- Latency: tx_data goes 0 in the cycle after accept; START is entered then.
- Bit timing:
  - Down-counter loaded with P-1 on every bit entry.
  - START, each DATA bit and PARITY each last exactly P cycles.
  - STOP lasts P (one), P + floor(P/2) (one-and-half) or 2P (two) cycles. tx_data=1 throughout.
- DATA:
  - Bit index runs 0..N-1 with N = clamped cfg_data_bits.
  - LSB-first sends s_data[i]; MSB-first sends s_data[N-1-i].
  - PARITY follows only if the latched mode is not none; otherwise STOP.
- Parity is computed as the XOR of the N latched data bits only:
  - even = XOR
  - odd = ~XOR
  - mark = 1
  - space = 0
- End of STOP (last cycle):
  - frame_done=1 for that cycle.
  - If a word is accepted in the same cycle, go to START next cycle (no idle gap).
  - Otherwise go to IDLE.
- Break:
  - break_req sampled in IDLE has priority over s_valid (s_ready=0).
  - BREAK: tx_data=0 while break_req=1, minimum P cycles.
  - After release (and minimum met), drive tx_data=1 for P cycles (mark-after-break), then IDLE. No frame_done.
  - break_req asserted during a frame is ignored until the frame completes. It then blocks the back-to-back accept and BREAK is entered from IDLE.
- tx_busy=1 whenever state != IDLE. It is registered with state, so it rises the cycle after accept.
- tx_data is registered; there are no glitches.

Test Plan:
- 8N1, baud_div=4, LSB, send 0xA5 → tx_data 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. frame_done at cycle 40 after accept. tx_busy high for cycles 1..40.
- 7E1, baud_div=3, send 0x41 → data 1,0,0,0,0,0,1; parity 0; 30-cycle frame. Repeat with odd parity → parity bit 1.
- 5 bits, MSB-first, mark parity, 1.5 stop, baud_div=5, send 0x13 → data 1,0,0,1,1; parity 1; stop held 7 cycles; frame_done on the 7th stop cycle.
- s_valid held high with words 0x55 and 0xAA, 8N2, baud_div=2 → s_ready pulses on the final stop cycle. The second start bit begins the very next cycle. Change cfg mid-frame → no effect on the current frame.
- break_req high for 10 cycles in IDLE with s_valid=1, baud_div=4 → s_ready=0, tx_data low 10 cycles then high 4 cycles, then the queued word is accepted. break_req raised mid-frame → frame finishes intact, then break.
- Assert reset during DATA bit 3 → tx_data=1, tx_busy=0 immediately. After release the next frame is clean. baud_div=0 → behaves as 2.
